// File: rtl/wb_sequencer_pkg.sv
// Shared types and constants for the register-file writeback sequencer.
package wb_pkg;

    // Writeback class handed over by main control.
    typedef enum logic [2:0] {
        ALU   = 3'd0,
        LOAD  = 3'd1,
        HI    = 3'd2,
        LO    = 3'd3,
        SLT   = 3'd4,
        SHIFT = 3'd5,
        LINK  = 3'd6,
        NONE  = 3'd7
    } wb_kind_t;

    // MentoReg write-data mux select codes.
    localparam logic [3:0] SEL_ALU   = 4'd0;
    localparam logic [3:0] SEL_MEM   = 4'd1;
    localparam logic [3:0] SEL_HI    = 4'd2;
    localparam logic [3:0] SEL_LO    = 4'd3;
    localparam logic [3:0] SEL_SP    = 4'd4;  // mux constant input holding SP_INIT
    localparam logic [3:0] SEL_ZERO  = 4'd5;
    localparam logic [3:0] SEL_ONE   = 4'd6;
    localparam logic [3:0] SEL_SHIFT = 4'd7;
    localparam logic [3:0] SEL_PC    = 4'd8;

    // Value wired to the SEL_SP mux input; the sequencer only selects it.
    localparam int SP_INIT = 227;

    typedef enum logic [2:0] {
        S_INIT     = 3'd0,
        S_IDLE     = 3'd1,
        S_WAIT_MEM = 3'd2,
        S_WAIT_MD  = 3'd3,
        S_WRITE    = 3'd4,
        S_ABORT    = 3'd5
    } state_t;

    // Mux select used during the WRITE cycle for a given class.
    function automatic logic [3:0] sel_for_kind(input wb_kind_t kind, input logic lt);
        case (kind)
            ALU:     sel_for_kind = SEL_ALU;
            LOAD:    sel_for_kind = SEL_MEM;
            HI:      sel_for_kind = SEL_HI;
            LO:      sel_for_kind = SEL_LO;
            SLT:     sel_for_kind = lt ? SEL_ONE : SEL_ZERO;
            SHIFT:   sel_for_kind = SEL_SHIFT;
            LINK:    sel_for_kind = SEL_PC;
            default: sel_for_kind = SEL_ALU;
        endcase
    endfunction

endpackage

// File: rtl/wb_sequencer_if.sv
// Handshake and register-file write bus between main control and the sequencer.
interface wb_sequencer_if;
    logic               start;
    wb_pkg::wb_kind_t   wb_kind;
    logic [4:0]         dest;
    logic               lt_flag;
    logic               md_busy;
    logic [3:0]         mux_sel;
    logic               reg_write;
    logic [4:0]         wr_reg;
    logic               busy;
    logic               done;
    logic               err;

    // Main control / datapath side.
    modport master (
        output start, wb_kind, dest, lt_flag, md_busy,
        input  mux_sel, reg_write, wr_reg, busy, done, err
    );

    // Sequencer side.
    modport slave (
        input  start, wb_kind, dest, lt_flag, md_busy,
        output mux_sel, reg_write, wr_reg, busy, done, err
    );
endinterface

// File: rtl/wb_sequencer.sv
// Multicycle writeback controller: one register-file write per instruction,
// waiting on memory latency or the mult/div unit as needed. After reset it
// writes the stack-pointer init value.
module wb_sequencer
    import wb_pkg::*;
#(
    parameter int MEM_LAT    = 1,
    parameter int MD_TIMEOUT = 64,
    parameter int SP_REG     = 29,
    parameter int LINK_REG   = 31
) (
    input  logic          clk,
    input  logic          reset_n,
    wb_sequencer_if.slave bus
);

    // One counter serves both waits: it must hold MD_TIMEOUT-1 and MEM_LAT-1 (<=14).
    localparam int CNT_W = $clog2(MD_TIMEOUT > 16 ? MD_TIMEOUT : 16);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             accept;
    wb_kind_t         kind_q;
    logic [4:0]       dest_q;
    logic             lt_q;
    logic [4:0]       wr_addr;

    // LINK always targets the link register; every other class uses dest.
    assign wr_addr = (kind_q == LINK) ? 5'(LINK_REG) : dest_q;

    // State, wait counter and per-instruction operand latches.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= S_INIT;
            cnt    <= '0;
            kind_q <= NONE;
            dest_q <= '0;
            lt_q   <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                kind_q <= bus.wb_kind;
                dest_q <= bus.dest;
                lt_q   <= bus.lt_flag;
            end
        end
    end

    // Next-state and counter update; start is only honoured in IDLE.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        case (state)
            S_INIT: state_next = S_IDLE;
            S_IDLE: begin
                if (bus.start) begin
                    accept = 1'b1;
                    case (bus.wb_kind)
                        LOAD: begin
                            state_next = S_WAIT_MEM;
                            cnt_next   = CNT_W'(MEM_LAT - 1);
                        end
                        HI, LO: begin
                            state_next = S_WAIT_MD;
                            cnt_next   = '0;
                        end
                        default: state_next = S_WRITE;
                    endcase
                end
            end
            S_WAIT_MEM: begin
                if (cnt == '0) state_next = S_WRITE;
                else           cnt_next   = cnt - 1'b1;
            end
            S_WAIT_MD: begin
                if (!bus.md_busy)                       state_next = S_WRITE;
                else if (cnt == CNT_W'(MD_TIMEOUT - 1)) state_next = S_ABORT;
                else                                    cnt_next   = cnt + 1'b1;
            end
            S_WRITE, S_ABORT: state_next = S_IDLE;
            default: state_next = S_INIT;
        endcase
    end

    // Moore output decode, forced to the reset values while reset_n is low.
    always_comb begin
        bus.mux_sel   = SEL_ALU;
        bus.reg_write = 1'b0;
        bus.wr_reg    = '0;
        bus.busy      = 1'b1;
        bus.done      = 1'b0;
        bus.err       = 1'b0;
        case (state)
            S_INIT: begin
                bus.reg_write = 1'b1;
                bus.wr_reg    = 5'(SP_REG);
                bus.mux_sel   = SEL_SP;
            end
            S_IDLE: bus.busy = 1'b0;
            S_WRITE: begin
                bus.done      = 1'b1;
                bus.mux_sel   = sel_for_kind(kind_q, lt_q);
                bus.wr_reg    = wr_addr;
                // $zero is never written, and NONE only reports completion.
                bus.reg_write = (kind_q != NONE) && (wr_addr != 5'd0);
            end
            S_ABORT: bus.err = 1'b1;
            default: ;
        endcase
        if (!reset_n) begin
            bus.mux_sel   = SEL_ALU;
            bus.reg_write = 1'b0;
            bus.wr_reg    = '0;
            bus.busy      = 1'b1;
            bus.done      = 1'b0;
            bus.err       = 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_sequencer.sv
// Self-checking bench for wb_sequencer: directed scenarios plus randomized
// instructions checked against a latency/result model of the writeback rules.
module tb_wb_sequencer;
    import wb_pkg::*;

    localparam int MEM_LAT    = 3;
    localparam int MD_TIMEOUT = 64;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    wb_sequencer_if bus();

    wb_sequencer #(
        .MEM_LAT(MEM_LAT), .MD_TIMEOUT(MD_TIMEOUT), .SP_REG(29), .LINK_REG(31)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    // Reference: result of one instruction from the writeback table.
    function automatic void ref_result(input wb_kind_t k, input logic [4:0] d, input logic lt,
                                       input int md_n, output int lat, output bit is_err,
                                       output logic [3:0] sel, output logic [4:0] addr,
                                       output logic we);
        int sel_tab [8] = '{0, 1, 2, 3, 5, 7, 8, 0};
        sel    = 4'(sel_tab[int'(k)]);
        if (k == SLT && lt) sel = 4'd6;
        addr   = (k == LINK) ? 5'd31 : d;
        we     = (k != NONE) && (addr != 5'd0);
        is_err = 1'b0;
        if (k == LOAD)                lat = 1 + MEM_LAT;
        else if (k == HI || k == LO) begin
            if (md_n >= MD_TIMEOUT) begin
                lat    = MD_TIMEOUT + 1;
                is_err = 1'b1;
            end else begin
                lat = md_n + 2;
            end
        end else                      lat = 1;
    endfunction

    // Issue one instruction from a negedge in IDLE; md_busy is high for the
    // first md_n cycles after acceptance; optionally pulse a stray start.
    // Returns at the negedge of the following IDLE cycle.
    task automatic run_op(input wb_kind_t k, input logic [4:0] d, input logic lt,
                          input int md_n, input int stray_at, input string name);
        int lat, seen;
        bit is_err;
        logic [3:0] sel;
        logic [4:0] addr;
        logic we, o_done, o_err, o_we;
        logic [3:0] o_sel;
        logic [4:0] o_addr;
        ref_result(k, d, lt, md_n, lat, is_err, sel, addr, we);
        bus.start   = 1'b1;
        bus.wb_kind = k;
        bus.dest    = d;
        bus.lt_flag = lt;
        bus.md_busy = (md_n > 0);
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
        bus.wb_kind = wb_kind_t'($urandom_range(0, 7));
        bus.dest    = 5'($urandom);
        bus.lt_flag = 1'($urandom);
        seen = 0;
        o_done = 0; o_err = 0; o_we = 0; o_sel = 0; o_addr = 0;
        for (int c = 1; c <= 200 && seen == 0; c++) begin
            @(negedge clk);
            if (bus.done || bus.err) begin
                seen   = c;
                o_done = bus.done;
                o_err  = bus.err;
                o_we   = bus.reg_write;
                o_sel  = bus.mux_sel;
                o_addr = bus.wr_reg;
            end else begin
                n_cmp++;
                if (bus.busy !== 1'b1 || bus.reg_write !== 1'b0 || bus.mux_sel !== 4'd0) begin
                    n_fail++;
                    $display("FAIL %s wait c=%0d: busy=%b we=%b sel=%0d, need busy=1 we=0 sel=0",
                             name, c, bus.busy, bus.reg_write, bus.mux_sel);
                end
            end
            bus.md_busy = (c <= md_n);
            bus.start   = (c == stray_at);
        end
        bus.start   = 1'b0;
        bus.md_busy = 1'b0;
        n_cmp++;
        if (seen == 0) begin
            n_fail++;
            $display("FAIL %s timeout: no done/err within 200 cycles, need latency %0d", name, lat);
            return;
        end
        if (seen !== lat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d, need %0d", name, seen, lat);
        end
        n_cmp++;
        if (is_err) begin
            if (o_err !== 1'b1 || o_done !== 1'b0 || o_we !== 1'b0) begin
                n_fail++;
                $display("FAIL %s abort: err=%b done=%b we=%b, need 1 0 0", name, o_err, o_done, o_we);
            end
        end else begin
            if (o_done !== 1'b1 || o_err !== 1'b0 || o_we !== we || o_sel !== sel ||
                (we && o_addr !== addr)) begin
                n_fail++;
                $display("FAIL %s write: done=%b err=%b we=%b sel=%0d reg=%0d, need 1 0 %b %0d %0d",
                         name, o_done, o_err, o_we, o_sel, o_addr, we, sel, addr);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0 || bus.reg_write !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle: busy=%b done=%b err=%b we=%b, need all 0",
                     name, bus.busy, bus.done, bus.err, bus.reg_write);
        end
    endtask

    // Hold reset for cycles, release, check the INIT write and that start is ignored there.
    task automatic do_reset(input int cycles, input string name);
        reset_n = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.reg_write !== 1'b0 || bus.busy !== 1'b1 || bus.mux_sel !== 4'd0 ||
                bus.wr_reg !== 5'd0 || bus.done !== 1'b0 || bus.err !== 1'b0) begin
                n_fail++;
                $display("FAIL %s in_reset: we=%b busy=%b sel=%0d reg=%0d done=%b err=%b, need 0 1 0 0 0 0",
                         name, bus.reg_write, bus.busy, bus.mux_sel, bus.wr_reg, bus.done, bus.err);
            end
        end
        bus.md_busy = 1'b0;
        reset_n     = 1'b1;
        bus.start   = 1'b1;
        bus.wb_kind = ALU;
        bus.dest    = 5'd5;
        #1;
        n_cmp++;
        if (bus.reg_write !== 1'b1 || bus.wr_reg !== 5'd29 || bus.mux_sel !== SEL_SP || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s init_write: we=%b reg=%0d sel=%0d busy=%b, need 1 29 4 1",
                     name, bus.reg_write, bus.wr_reg, bus.mux_sel, bus.busy);
        end
        @(negedge clk);
        bus.start = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.reg_write !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s post_init_idle: busy=%b we=%b done=%b, need 0 0 0",
                     name, bus.busy, bus.reg_write, bus.done);
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.wb_kind = ALU; bus.dest = '0; bus.lt_flag = 1'b0; bus.md_busy = 1'b0;
        do_reset(3, "reset");
    endtask

    task automatic test_alu_slt();
        run_op(ALU, 5'd8, 1'b0, 0, 0, "alu");
        run_op(SLT, 5'd9, 1'b1, 0, 0, "slt_lt1");
        run_op(SLT, 5'd9, 1'b0, 0, 0, "slt_lt0");
        run_op(SHIFT, 5'd14, 1'b0, 0, 0, "shift");
    endtask

    task automatic test_load();
        run_op(LOAD, 5'd10, 1'b0, 0, 2, "load_stray_start");
    endtask

    task automatic test_md();
        run_op(HI, 5'd11, 1'b0, 5, 0, "hi_busy5");
        run_op(LO, 5'd12, 1'b0, 0, 0, "lo_ready");
        run_op(HI, 5'd13, 1'b0, MD_TIMEOUT - 1, 0, "hi_edge_ok");
        run_op(LO, 5'd13, 1'b0, MD_TIMEOUT, 0, "lo_timeout");
        run_op(HI, 5'd13, 1'b0, MD_TIMEOUT + 20, 0, "hi_timeout");
    endtask

    task automatic test_link_zero();
        run_op(LINK, 5'd3, 1'b0, 0, 0, "link");
        run_op(ALU, 5'd0, 1'b0, 0, 0, "alu_zero");
        run_op(NONE, 5'd7, 1'b0, 0, 0, "none");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            wb_kind_t k;
            int md_n;
            k    = wb_kind_t'($urandom_range(0, 7));
            md_n = ($urandom_range(0, 9) == 0) ? $urandom_range(MD_TIMEOUT - 2, MD_TIMEOUT + 3)
                                               : $urandom_range(0, 8);
            run_op(k, 5'($urandom), 1'($urandom), md_n, (k == LOAD) ? $urandom_range(1, MEM_LAT) : 0, "random");
        end
    endtask

    task automatic test_reset_mid_wait();
        bus.start = 1'b1; bus.wb_kind = HI; bus.dest = 5'd20; bus.md_busy = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.done !== 1'b0 || bus.reg_write !== 1'b0 || bus.busy !== 1'b1) begin
                n_fail++;
                $display("FAIL mid_wait_pre: done=%b we=%b busy=%b, need 0 0 1", bus.done, bus.reg_write, bus.busy);
            end
        end
        bus.md_busy = 1'b0;
        do_reset(3, "reset_mid_wait");
        run_op(ALU, 5'd4, 1'b0, 0, 0, "after_reset");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_alu_slt();
        test_load();
        test_md();
        test_link_zero();
        test_back_to_back();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
